// File: rtl/ahb_sdram_frontend_if.sv
// Bundle of the AHB-Lite slave port and the SDRAM core request/response channels.
// slave = the front-end's view, master = the bus master plus core side.
interface ahb_sdram_frontend_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 16
);
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic          hmasterlock;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-2:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_byteen;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hmasterlock, hprot,
    input  hwdata, hready,
    output hreadyout, hresp, hrdata,
    output req_valid, req_write, req_addr, req_wdata, req_byteen,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hmasterlock, hprot,
    output hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  req_valid, req_write, req_addr, req_wdata, req_byteen,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ahb_sdram_frontend.sv
// AHB-Lite slave front-end for the SDRAM controller core: each accepted transfer
// becomes one single-beat request, with AHB wait states until the core completes it.
module ahb_sdram_frontend #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ahb_sdram_frontend_if.slave  bus
);
  localparam int unsigned RAW = AW - 1;
  localparam int unsigned BEW = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_REQ  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_ERR1    = 3'd4;
  localparam logic [2:0] ST_ERR2    = 3'd5;

  // Reset: asserts asynchronously, releases on a clock edge.
  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;

  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  logic [2:0]     state_q, state_d;
  logic           hreadyout_q, hreadyout_d;
  logic           hresp_q, hresp_d;
  logic [DW-1:0]  hrdata_q, hrdata_d;
  logic           req_valid_q, req_valid_d;
  logic           req_write_q, req_write_d;
  logic [RAW-1:0] req_addr_q, req_addr_d;
  logic [BEW-1:0] req_byteen_q, req_byteen_d;

  logic           accept_c;
  logic           legal_c;
  logic [BEW-1:0] byteen_c;
  logic           unused_ok_c;

  // Transfer qualification and size/alignment decode of the current address phase.
  always_comb begin
    accept_c = bus.hsel & bus.hready & bus.htrans[1];
    legal_c  = 1'b1;
    byteen_c = '0;
    case (bus.hsize)
      3'd0: byteen_c = bus.haddr[0] ? 2'b10 : 2'b01;
      3'd1: begin
        if (bus.haddr[0]) begin
          legal_c = 1'b0;
        end else begin
          byteen_c = 2'b11;
        end
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Next state, captured request fields, and registered outputs for the next state.
  always_comb begin
    state_d      = state_q;
    hrdata_d     = hrdata_q;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    req_byteen_d = req_byteen_q;
    hreadyout_d  = 1'b1;
    hresp_d      = 1'b0;
    req_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (!legal_c) begin
            state_d = ST_ERR1;
          end else begin
            state_d      = bus.hwrite ? ST_WR_REQ : ST_RD_REQ;
            req_write_d  = bus.hwrite;
            req_addr_d   = bus.haddr[AW-1:1];
            req_byteen_d = byteen_c;
          end
        end
      end
      ST_WR_REQ: begin
        if (bus.req_ready) state_d = ST_IDLE;
      end
      ST_RD_REQ: begin
        if (bus.req_ready) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.rsp_valid) begin
          hrdata_d = bus.rsp_rdata;
          state_d  = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WR_REQ, ST_RD_REQ: begin
        hreadyout_d = 1'b0;
        req_valid_d = 1'b1;
      end
      ST_RD_WAIT: hreadyout_d = 1'b0;
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ST_ERR2: hresp_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q      <= ST_IDLE;
      hreadyout_q  <= 1'b1;
      hresp_q      <= 1'b0;
      hrdata_q     <= '0;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_byteen_q <= '0;
    end else begin
      state_q      <= state_d;
      hreadyout_q  <= hreadyout_d;
      hresp_q      <= hresp_d;
      hrdata_q     <= hrdata_d;
      req_valid_q  <= req_valid_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      req_byteen_q <= req_byteen_d;
    end
  end

  // Write data passes straight through: the master holds hwdata for the whole data phase.
  assign bus.req_wdata  = (state_q == ST_WR_REQ) ? bus.hwdata : DW'(0);
  assign bus.hreadyout  = hreadyout_q;
  assign bus.hresp      = hresp_q;
  assign bus.hrdata     = hrdata_q;
  assign bus.req_valid  = req_valid_q;
  assign bus.req_write  = req_write_q;
  assign bus.req_addr   = req_addr_q;
  assign bus.req_byteen = req_byteen_q;

  assign unused_ok_c = ^{bus.hburst, bus.hmasterlock, bus.hprot, bus.htrans[0]};

endmodule

// File: tb/tb_ahb_sdram_frontend.sv
// Randomized bench for ahb_sdram_frontend: a bus master, a responding core model,
// and a transfer-level reference that predicts requests, wait states and responses.
module tb_ahb_sdram_frontend;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb_sdram_frontend_if #(.AW(AW), .DW(DW)) bus ();
  ahb_sdram_frontend #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Single-slave system: the bus HREADY is this slave's HREADYOUT.
  assign bus.hready = bus.hreadyout;

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [1:0]    be;
    logic          wr;
    logic [DW-1:0] wd;
    logic          stable;
  } req_t;

  req_t          got_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cfg_rdly, cfg_rspdly;
  logic [DW-1:0] cfg_rdata;
  logic [DW-1:0] last_rd;
  logic          spur_en, inj_rsp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Core model: accepts after cfg_rdly stall cycles, answers reads cfg_rspdly cycles later.
  int            vcnt, rsp_left;
  logic [AW-2:0] a0;
  logic [1:0]    b0;
  logic          w0, moved;
  logic [DW-1:0] d0;

  initial begin
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = '0;
    vcnt = 0; rsp_left = 0; moved = 1'b0;
    forever begin
      @(negedge clk);
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = DW'($urandom);
      if (!rst_n) begin
        vcnt = 0; rsp_left = 0;
      end else if (inj_rsp) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 16'h5555;
      end else if (rsp_left > 0) begin
        rsp_left--;
        if (rsp_left == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = cfg_rdata;
        end
      end else if (bus.req_valid) begin
        if (vcnt == 0) begin
          a0 = bus.req_addr; b0 = bus.req_byteen; w0 = bus.req_write; d0 = bus.req_wdata;
          moved = 1'b0;
        end else if ({a0, b0, w0, d0} !== {bus.req_addr, bus.req_byteen, bus.req_write, bus.req_wdata}) begin
          moved = 1'b1;
        end
        if (vcnt == cfg_rdly) begin
          bus.req_ready = 1'b1;
          got_q.push_back('{addr: bus.req_addr, be: bus.req_byteen, wr: bus.req_write,
                            wd: bus.req_wdata, stable: !moved});
          vcnt = 0;
          if (!bus.req_write) rsp_left = cfg_rspdly;
        end else begin
          vcnt++;
        end
      end else begin
        vcnt = 0;
        if (spur_en && $urandom_range(3) == 0) bus.rsp_valid = 1'b1;
      end
    end
  end

  // One AHB transfer; entered and left at a negedge where hreadyout is high.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [2:0] size,
                      input logic [1:0] trans, input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                      input int rdly, input int rspdly);
    logic legal, resp_first;
    logic [1:0] exp_be;
    int low, exp_low;
    req_t r;
    legal   = (size == 3'd0) || (size == 3'd1 && addr[0] == 1'b0);
    exp_be  = (size == 3'd0) ? 2'(1 << addr[0]) : 2'b11;
    exp_low = !legal ? 1 : (wr ? rdly + 1 : rdly + rspdly + 1);
    cfg_rdly = rdly; cfg_rspdly = rspdly; cfg_rdata = rd;
    bus.hsel = 1'b1; bus.haddr = addr; bus.htrans = trans; bus.hwrite = wr; bus.hsize = size;
    bus.hburst = 3'($urandom); bus.hprot = 4'($urandom); bus.hmasterlock = 1'($urandom);
    bus.hwdata = wd;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    bus.haddr = AW'($urandom); bus.hwrite = 1'($urandom); bus.hsize = 3'($urandom);
    resp_first = bus.hresp;
    low = 0;
    while (bus.hreadyout !== 1'b1 && low < 200) begin
      low++;
      @(negedge clk);
    end
    if (legal && !wr) last_rd = rd;
    check_eq("wait_states", 32'(low), 32'(exp_low));
    check_eq("hresp_first", 32'(resp_first), 32'(!legal));
    check_eq("hresp_last", 32'(bus.hresp), 32'(!legal));
    check_eq("hrdata", 32'(bus.hrdata), 32'(last_rd));
    check_eq("req_count", 32'(got_q.size()), legal ? 32'd1 : 32'd0);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      check_eq("req_addr", 32'(r.addr), 32'(addr >> 1));
      check_eq("req_byteen", 32'(r.be), 32'(exp_be));
      check_eq("req_write", 32'(r.wr), 32'(wr));
      check_eq("req_stable", 32'(r.stable), 32'd1);
      if (wr) check_eq("req_wdata", 32'(r.wd), 32'(wd));
    end
  endtask

  // A cycle with no transfer (unselected, IDLE or BUSY): zero-wait OKAY, no request.
  task automatic idle_cycle();
    logic sel;
    sel = 1'($urandom);
    bus.hsel = sel;
    bus.htrans = sel ? 2'($urandom_range(1)) : 2'($urandom);
    bus.haddr = AW'($urandom); bus.hwrite = 1'($urandom); bus.hsize = 3'($urandom);
    @(negedge clk);
    check_eq("idle_hreadyout", 32'(bus.hreadyout), 32'd1);
    check_eq("idle_hresp", 32'(bus.hresp), 32'd0);
    check_eq("idle_req_valid", 32'(bus.req_valid), 32'd0);
    check_eq("idle_hrdata", 32'(bus.hrdata), 32'(last_rd));
  endtask

  task automatic check_reset_values(input string phase);
    check_eq({phase, "_hreadyout"}, 32'(bus.hreadyout), 32'd1);
    check_eq({phase, "_hresp"}, 32'(bus.hresp), 32'd0);
    check_eq({phase, "_hrdata"}, 32'(bus.hrdata), 32'd0);
    check_eq({phase, "_req_valid"}, 32'(bus.req_valid), 32'd0);
    check_eq({phase, "_req_write"}, 32'(bus.req_write), 32'd0);
    check_eq({phase, "_req_addr"}, 32'(bus.req_addr), 32'd0);
    check_eq({phase, "_req_byteen"}, 32'(bus.req_byteen), 32'd0);
    check_eq({phase, "_req_wdata"}, 32'(bus.req_wdata), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] sz;
    rst_n = 1'b1;
    bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hsize = 3'd0;
    bus.hburst = 3'd0; bus.hmasterlock = 1'b0; bus.hprot = 4'd0; bus.hwdata = 16'hFFFF;
    spur_en = 1'b0; inj_rsp = 1'b0; last_rd = '0;
    cfg_rdly = 0; cfg_rspdly = 1; cfg_rdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    xfer(24'h000100, 1'b1, 3'd1, 2'b10, 16'hBEEF, 16'h0000, 3, 1);
    xfer(24'h000100, 1'b0, 3'd1, 2'b10, 16'h0000, 16'h1234, 0, 6);
    xfer(24'h000201, 1'b1, 3'd0, 2'b10, 16'hAB00, 16'h0000, 1, 1);
    xfer(24'h000200, 1'b1, 3'd0, 2'b10, 16'h00CD, 16'h0000, 0, 1);
    xfer(24'h000000, 1'b1, 3'd2, 2'b10, 16'h1111, 16'h0000, 0, 1);
    xfer(24'h000003, 1'b0, 3'd1, 2'b10, 16'h2222, 16'h0000, 0, 1);
    xfer(24'h000010, 1'b1, 3'd1, 2'b10, 16'h0010, 16'h0000, 0, 1);
    xfer(24'h000012, 1'b1, 3'd1, 2'b11, 16'h0012, 16'h0000, 5, 1);
    xfer(24'h000014, 1'b1, 3'd1, 2'b11, 16'h0014, 16'h0000, 0, 1);
    xfer(24'h000016, 1'b1, 3'd1, 2'b11, 16'h0016, 16'h0000, 2, 1);

    spur_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(4) == 0) begin
        idle_cycle();
      end else begin
        case ($urandom_range(9))
          0, 1, 2, 3: sz = 3'd0;
          4, 5, 6, 7: sz = 3'd1;
          default:    sz = 3'($urandom_range(7, 2));
        endcase
        xfer(AW'($urandom), 1'($urandom), sz, 2'($urandom_range(3, 2)),
             DW'($urandom), DW'($urandom), $urandom_range(4), $urandom_range(6, 1));
      end
    end
    spur_en = 1'b0;

    // Reset while a read waits for its response.
    xfer(24'h000042, 1'b0, 3'd1, 2'b10, 16'h0000, 16'hA5A5, 1, 2);
    cfg_rdly = 0; cfg_rspdly = 1000;
    bus.hsel = 1'b1; bus.haddr = 24'h000100; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.hsize = 3'd1;
    bus.hwdata = 16'h7777;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    @(negedge clk);
    check_eq("rdwait_hreadyout", 32'(bus.hreadyout), 32'd0);
    check_eq("rdwait_req_valid", 32'(bus.req_valid), 32'd0);
    check_eq("rdwait_hrdata", 32'(bus.hrdata), 32'hA5A5);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    last_rd = '0;
    repeat (3) @(negedge clk);
    #2 inj_rsp = 1'b1;
    @(negedge clk);
    #2 inj_rsp = 1'b0;
    @(negedge clk);
    check_eq("post_reset_hrdata", 32'(bus.hrdata), 32'd0);
    check_eq("post_reset_hreadyout", 32'(bus.hreadyout), 32'd1);
    check_eq("post_reset_req_valid", 32'(bus.req_valid), 32'd0);
    xfer(24'h000300, 1'b0, 3'd0, 2'b10, 16'h0000, 16'h0F0F, 2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_sdram_frontend.md
Name: ahb_sdram_frontend

Overview:
- AHB-Lite slave front-end placed directly upstream of the SDRAM controller core.
- Converts AHB-Lite address/data-phase transfers into a single-beat valid/ready request channel and a read-response channel.
- Inserts AHB wait states until the core accepts each request and, for reads, returns data.
- Decodes size and alignment into halfword address and byte enables; illegal sizes get a two-cycle ERROR response.

Parameters:
AW, 24, AHB byte address width
DW, 16, data width (SDRAM DQ width); only 16 supported

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  AW  byte address
htrans  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
hwrite  in  1  1=write
hsize  in  3  transfer size
hburst  in  3  burst type (ignored; beats handled individually)
hmasterlock  in  1  ignored
hprot  in  4  ignored
hwdata  in  DW  write data (data phase)
hready  in  1  bus HREADY (previous transfer complete)
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  DW  read data
req_valid  out  1  request valid to core
req_ready  in  1  core accepts request
req_write  out  1  1=write request
req_addr  out  AW-1  halfword address (haddr[AW-1:1])
req_wdata  out  DW  write data
req_byteen  out  2  byte enables, [1]=upper byte
rsp_valid  in  1  read data valid from core
rsp_rdata  in  DW  read data

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE, hreadyout=1, hresp=0, hrdata=0, req_valid=0, req_write=0, req_addr=0, req_wdata=0, req_byteen=0.
- Address phase accepted when hsel & hready & htrans[1]. On acceptance, register haddr, hwrite, hsize. IDLE/BUSY transfers and unselected cycles leave state IDLE and get zero-wait OKAY.
- Size decode:
  - hsize=0: byteen = haddr[0] ? 2'b10 : 2'b01.
  - hsize=1 with haddr[0]=0: byteen=2'b11.
  - hsize=1 with haddr[0]=1, or hsize>=2: error path. No request is issued.
- States:
  - IDLE: hreadyout=1, hresp=0. Accepted transfer moves to WR_REQ (write), RD_REQ (read) or ERR1 (illegal).
  - WR_REQ: hreadyout=0, req_valid=1, req_write=1, req_wdata=hwdata (stable during data phase). On req_ready, go to IDLE. Minimum write data phase is 2 cycles.
  - RD_REQ: hreadyout=0, req_valid=1, req_write=0. On req_ready, go to RD_WAIT.
  - RD_WAIT: hreadyout=0, req_valid=0. On rsp_valid, hrdata<=rsp_rdata and go to IDLE; hreadyout=1 with valid hrdata on the next cycle. Full 16 bits are returned; the master selects the byte lane.
  - ERR1: hreadyout=0, hresp=1, then ERR2.
  - ERR2: hreadyout=1, hresp=1. A new address phase accepted here is decoded as from IDLE.
- req_addr, req_byteen and req_write remain stable while req_valid=1 and req_ready=0. req_valid never drops before the handshake.
- rsp_valid outside RD_WAIT is ignored; hrdata holds its last value.
- The core guarantees rsp_valid no earlier than the cycle after the read handshake.
- Back-to-back transfers: the next address phase is only sampled when hready=1. Since hreadyout is held low through WR_REQ/RD_REQ/RD_WAIT/ERR1, only one transaction is outstanding.
- hburst is ignored; each SEQ beat is an independent request. Wrap/incr address generation is the master's responsibility.
- Reset mid-transaction aborts immediately; the core shares rst_n.

Test Plan:
- Halfword write to haddr=0x000100, hwdata=0xBEEF, req_ready high 3 cycles after req_valid → req_addr=0x000080, req_byteen=2'b11, req_wdata=0xBEEF; hreadyout low 4 cycles then high; hresp=0.
- Halfword read from haddr=0x000100, req_ready immediate, rsp_valid with 0x1234 six cycles later → hrdata=0x1234 on the cycle hreadyout returns 1; exactly one request issued.
- Byte writes to 0x000201 (0xAB00) and 0x000200 (0x00CD) → req_byteen=2'b10 then 2'b01; both req_addr=0x000100.
- hsize=2 to 0x000000, then misaligned halfword to 0x000003 → each gives a two-cycle ERROR (hreadyout 0/1, hresp 1/1); req_valid never asserts.
- INCR4 burst of writes 0x10..0x16 with req_ready stuck low for 5 cycles on beat 2 → four requests in order; addresses 0x08..0x0B; req_addr/req_wdata stable during the stall.
- rst_n asserted while in RD_WAIT → all outputs return to reset values asynchronously; rsp_valid after release is ignored and hrdata=0.
